rect_hit_tree: RTL and testbench

//  Per-pixel rectangle hit resolver for the GPU. Holds RECT_COUNT absolute rectangles, loaded

---
 rtl/rect_hit_pkg.sv | 34 +++
 rtl/rect_cmp.sv | 26 ++
 rtl/rect_hit_tree.sv | 136 +++++++++++++
 tb/tb_rect_hit_tree.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rect_hit_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : rect_hit_pkg                                                     |
// | Purpose : Shared field selects, default colour and tree-node select helper |
// |           for the rectangle hit resolver.                                  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package rect_hit_pkg;

    localparam logic [2:0]  FLD_LEFT   = 3'd0;
    localparam logic [2:0]  FLD_TOP    = 3'd1;
    localparam logic [2:0]  FLD_WIDTH  = 3'd2;
    localparam logic [2:0]  FLD_HEIGHT = 3'd3;
    localparam logic [2:0]  FLD_COLOR  = 3'd4;

    localparam logic [15:0] DEFAULT_COLOR = 16'h0000;

    typedef struct packed {
        logic flag;
        logic sel_b;
    } node_sel_t;

    // The higher-index child wins whenever it has a hit.
    function automatic node_sel_t node_select(input logic flag_a, input logic flag_b);
        node_sel_t s;
        s.flag  = flag_a | flag_b;
        s.sel_b = flag_b;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rect_cmp.sv
// +----------------------------------------------------------------------------+
// | Module  : rect_cmp                                                         |
// | Purpose : Combinational point-in-rectangle test; left/top inclusive,       |
// |           right/bottom exclusive, unsigned compare.                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module rect_cmp #(
    parameter int COORD_WIDTH = 16
) (
    input  logic [COORD_WIDTH-1:0] x_i,
    input  logic [COORD_WIDTH-1:0] y_i,
    input  logic [COORD_WIDTH-1:0] left_i,
    input  logic [COORD_WIDTH-1:0] top_i,
    input  logic [COORD_WIDTH-1:0] right_i,
    input  logic [COORD_WIDTH-1:0] bottom_i,
    output logic                   hit_o
);

    assign hit_o = (left_i <= x_i) && (x_i < right_i) &&
                   (top_i  <= y_i) && (y_i < bottom_i);

endmodule

`default_nettype wire

// File: rtl/rect_hit_tree.sv
// +----------------------------------------------------------------------------+
// | Module  : rect_hit_tree                                                    |
// | Purpose : Rect store, parallel per-rect hit test and priority-mux tree     |
// |           returning the highest-index hit and its colour.                  |
// |           Define RECT_HIT_PIPE_EN to register the outputs at the root.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module rect_hit_tree #(
    parameter int          RECT_COUNT    = 64,
    parameter int          IDX_W         = 6,
    parameter int          COORD_WIDTH   = 16,
    parameter logic [15:0] DEFAULT_COLOR = rect_hit_pkg::DEFAULT_COLOR
) (
    input  logic                   pixel_clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [2:0]             we_field,
    input  logic [IDX_W-1:0]       wr_addr,
    input  logic [15:0]            wr_data,
    input  logic [COORD_WIDTH-1:0] x_coord,
    input  logic [COORD_WIDTH-1:0] y_coord,
    output logic                   hit,
    output logic [IDX_W-1:0]       hit_idx,
    output logic [15:0]            color
);

    import rect_hit_pkg::*;

    logic [COORD_WIDTH-1:0] left_q   [RECT_COUNT];
    logic [COORD_WIDTH-1:0] top_q    [RECT_COUNT];
    logic [COORD_WIDTH-1:0] right_q  [RECT_COUNT];
    logic [COORD_WIDTH-1:0] bottom_q [RECT_COUNT];
    logic [15:0]            col_mem_q[RECT_COUNT];

    logic [COORD_WIDTH-1:0] wr_coord;
    assign wr_coord = COORD_WIDTH'(wr_data);

    // Width/height are converted to absolute right/bottom edges at write time
    // using the edge already stored, so the compare path needs no adders.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            for (int i = 0; i < RECT_COUNT; i++) begin
                left_q[i]    <= '0;
                top_q[i]     <= '0;
                right_q[i]   <= '0;
                bottom_q[i]  <= '0;
                col_mem_q[i] <= '0;
            end
        end else if (we) begin
            case (we_field)
                FLD_LEFT:   left_q[wr_addr]    <= wr_coord;
                FLD_TOP:    top_q[wr_addr]     <= wr_coord;
                FLD_WIDTH:  right_q[wr_addr]   <= wr_coord + left_q[wr_addr];
                FLD_HEIGHT: bottom_q[wr_addr]  <= wr_coord + top_q[wr_addr];
                FLD_COLOR:  col_mem_q[wr_addr] <= wr_data;
                default:    ;
            endcase
        end
    end

    logic [RECT_COUNT-1:0] coll;

    for (genvar i = 0; i < RECT_COUNT; i++) begin : g_cmp
        rect_cmp #(
            .COORD_WIDTH(COORD_WIDTH)
        ) u_cmp (
            .x_i      (x_coord),
            .y_i      (y_coord),
            .left_i   (left_q[i]),
            .top_i    (top_q[i]),
            .right_i  (right_q[i]),
            .bottom_i (bottom_q[i]),
            .hit_o    (coll[i])
        );
    end

    // Level 0 holds the leaves; level IDX_W is the single root node.
    for (genvar l = 0; l <= IDX_W; l++) begin : g_lvl
        localparam int N = RECT_COUNT >> l;
        logic [N-1:0]     flag;
        logic [IDX_W-1:0] idx [N];

        if (l == 0) begin : g_leaves
            for (genvar i = 0; i < N; i++) begin : g_leaf
                assign flag[i] = coll[i];
                assign idx[i]  = IDX_W'(i);
            end
        end else begin : g_nodes
            for (genvar j = 0; j < N; j++) begin : g_node
                node_sel_t sel;
                assign sel     = node_select(g_lvl[l-1].flag[2*j], g_lvl[l-1].flag[2*j+1]);
                assign flag[j] = sel.flag;
                assign idx[j]  = sel.sel_b ? g_lvl[l-1].idx[2*j+1] : g_lvl[l-1].idx[2*j];
            end
        end
    end

    logic             root_hit;
    logic [IDX_W-1:0] root_idx;
    logic [15:0]      root_color;

    assign root_hit   = g_lvl[IDX_W].flag[0];
    assign root_idx   = g_lvl[IDX_W].idx[0];
    assign root_color = root_hit ? col_mem_q[root_idx] : DEFAULT_COLOR;

`ifdef RECT_HIT_PIPE_EN
    logic             hit_q;
    logic [IDX_W-1:0] hit_idx_q;
    logic [15:0]      color_q;

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            color_q   <= DEFAULT_COLOR;
        end else begin
            hit_q     <= root_hit;
            hit_idx_q <= root_idx;
            color_q   <= root_color;
        end
    end

    assign hit     = hit_q;
    assign hit_idx = hit_idx_q;
    assign color   = color_q;
`else
    assign hit     = root_hit;
    assign hit_idx = root_idx;
    assign color   = root_color;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rect_hit_tree.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_rect_hit_tree                                                 |
// | Purpose : Directed and randomized checks of rect_hit_tree against a        |
// |           behavioural rectangle-list model.                                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rect_hit_tree;

    logic        pixel_clk = 1'b0;
    logic        reset     = 1'b1;
    logic        we        = 1'b0;
    logic [2:0]  we_field  = 3'd0;
    logic [5:0]  wr_addr   = 6'd0;
    logic [15:0] wr_data   = 16'd0;
    logic [15:0] x_coord   = 16'd0;
    logic [15:0] y_coord   = 16'd0;
    logic        hit;
    logic [5:0]  hit_idx;
    logic [15:0] color;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_l [64];
    logic [15:0] m_t [64];
    logic [15:0] m_r [64];
    logic [15:0] m_b [64];
    logic [15:0] m_c [64];

    rect_hit_tree dut (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .we        (we),
        .we_field  (we_field),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .x_coord   (x_coord),
        .y_coord   (y_coord),
        .hit       (hit),
        .hit_idx   (hit_idx),
        .color     (color)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            m_l[i] = '0; m_t[i] = '0; m_r[i] = '0; m_b[i] = '0; m_c[i] = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
    endtask

    task automatic wr(input int idx, input int fld, input logic [15:0] data);
        we       = 1'b1;
        we_field = 3'(fld);
        wr_addr  = 6'(idx);
        wr_data  = data;
        tick();
        we = 1'b0;
        case (fld)
            0: m_l[idx] = data;
            1: m_t[idx] = data;
            2: m_r[idx] = data + m_l[idx];
            3: m_b[idx] = data + m_t[idx];
            4: m_c[idx] = data;
            default: ;
        endcase
    endtask

    task automatic wr_rect(input int idx, input logic [15:0] l, input logic [15:0] t,
                           input logic [15:0] w, input logic [15:0] h, input logic [15:0] c);
        wr(idx, 0, l);
        wr(idx, 1, t);
        wr(idx, 2, w);
        wr(idx, 3, h);
        wr(idx, 4, c);
    endtask

    // Scan the rect list in z-order; the last (topmost) containing rect wins.
    function automatic void ref_hit(input logic [15:0] x, input logic [15:0] y,
                                    output logic h, output logic [5:0] id, output logic [15:0] c);
        h = 1'b0; id = '0; c = 16'h0000;
        for (int i = 0; i < 64; i++) begin
            if (m_l[i] <= x && x < m_r[i] && m_t[i] <= y && y < m_b[i]) begin
                h = 1'b1; id = 6'(i); c = m_c[i];
            end
        end
    endfunction

    task automatic apply_xy(input logic [15:0] x, input logic [15:0] y);
        x_coord = x;
        y_coord = y;
`ifdef RECT_HIT_PIPE_EN
        tick();
`else
        #1;
`endif
    endtask

    task automatic probe_exp(input string tag, input logic [15:0] x, input logic [15:0] y,
                             input logic eh, input logic [5:0] eid, input logic [15:0] ec);
        apply_xy(x, y);
        check({tag, ".hit"},   32'(hit),     32'(eh));
        check({tag, ".idx"},   32'(hit_idx), 32'(eid));
        check({tag, ".color"}, 32'(color),   32'(ec));
    endtask

    task automatic probe_model(input logic [15:0] x, input logic [15:0] y);
        logic        eh;
        logic [5:0]  eid;
        logic [15:0] ec;
        apply_xy(x, y);
        ref_hit(x, y, eh, eid, ec);
        check("rnd.hit",   32'(hit),     32'(eh));
        check("rnd.idx",   32'(hit_idx), 32'(eid));
        check("rnd.color", 32'(color),   32'(ec));
    endtask

    initial begin
        model_clear();
        x_coord = 16'd5;
        y_coord = 16'd5;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset.hit",   32'(hit),     32'd0);
        check("reset.idx",   32'(hit_idx), 32'd0);
        check("reset.color", 32'(color),   32'h0000);

        wr_rect(3, 16'd10, 16'd20, 16'd5, 16'd5, 16'hF800);
        probe_exp("r3.tl",     16'd10, 16'd20, 1'b1, 6'd3, 16'hF800);
        probe_exp("r3.in",     16'd14, 16'd24, 1'b1, 6'd3, 16'hF800);
        probe_exp("r3.right",  16'd15, 16'd20, 1'b0, 6'd0, 16'h0000);
        probe_exp("r3.bottom", 16'd10, 16'd25, 1'b0, 6'd0, 16'h0000);

        wr_rect(7, 16'd12, 16'd22, 16'd10, 16'd10, 16'h07E0);
        probe_exp("r7.ovl",  16'd13, 16'd23, 1'b1, 6'd7, 16'h07E0);
        probe_exp("r7.low",  16'd11, 16'd21, 1'b1, 6'd3, 16'hF800);
        probe_exp("r7.only", 16'd20, 16'd30, 1'b1, 6'd7, 16'h07E0);

        wr_rect(0,  16'd0, 16'd0, 16'd100, 16'd100, 16'h0001);
        wr_rect(63, 16'd0, 16'd0, 16'd100, 16'd100, 16'hFFFF);
        probe_exp("r63.top", 16'd50, 16'd50, 1'b1, 6'd63, 16'hFFFF);
        wr(63, 2, 16'd0);
        probe_exp("r63.w0",  16'd50, 16'd50, 1'b1, 6'd0, 16'h0001);

        wr(0, 5, 16'h1234);
        wr(0, 7, 16'h0000);
        probe_exp("fld.ign", 16'd50, 16'd50, 1'b1, 6'd0, 16'h0001);

        wr_rect(1, 16'hFFF0, 16'd0, 16'h0020, 16'd100, 16'h00AA);
        probe_exp("wrap.hi",  16'hFFF5, 16'd5, 1'b0, 6'd0, 16'h0000);
        probe_exp("wrap.lo",  16'h0005, 16'd5, 1'b1, 6'd0, 16'h0001);
        probe_exp("wrap.out", 16'h0200, 16'd5, 1'b0, 6'd0, 16'h0000);

        wr(2, 0, 16'd0);
        wr(2, 2, 16'd50);
        x_coord = 16'd5;
        y_coord = 16'd5;
        do_reset();
        #1;
        check("rst2.hit",   32'(hit),     32'd0);
        check("rst2.idx",   32'(hit_idx), 32'd0);
        check("rst2.color", 32'(color),   32'h0000);
        probe_exp("rst2.probe", 16'd5, 16'd5, 1'b0, 6'd0, 16'h0000);

        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 3);
            if (r == 0) begin
                logic [15:0] l;
                l = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(16'hFFC0, 16'hFFFF))
                                                : 16'($urandom_range(0, 60));
                wr_rect($urandom_range(0, 63), l, 16'($urandom_range(0, 60)),
                        16'($urandom_range(0, 40)), 16'($urandom_range(0, 40)),
                        16'($urandom));
            end else if (r == 1 && $urandom_range(0, 3) == 0) begin
                wr($urandom_range(0, 63), $urandom_range(5, 7), 16'($urandom));
            end
            probe_model(16'($urandom_range(0, 110)), 16'($urandom_range(0, 110)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
